nandn_filt_xloop: RTL and testbench
===================================

# nandn_filt_XLOOP

Parametrised multi-channel N-input NAND brick with input synchronisation and a per-channel debounce filter. It is the clocked successor to the fixed two-input NAND brick used in LOOP/CONTROL of the step-down regulator. Each channel NANDs its inputs and propagates a change to its output only after the raw result has been stable for a programmed number of clocks. An optional per-channel transition counter can be compiled in for loop-activity diagnostics.

## Interface
- `NCH`, default 1: number of independent channels (≥1).
- `NIN`, default 2: inputs per channel NAND (≥2).
- `FILT_CYC`, default 4: consecutive cycles a changed raw result must hold before `o` follows; 0 = no filter.
- `EVCW`, default 8: transition-counter width per channel; used only with the macro.

- `CELCLK`, input, 1: sole clock, rising edge.
- `CELRSTN`, input, 1: asynchronous active-low reset.
- `CELV`, input, 1: supply tie, carried for netlist compatibility, no logic function.
- `CELG`, input, 1: ground tie, no logic function.
- `SUB`, input, 1: substrate tie, no logic function.
- `i`, input, NCH*NIN: channel c uses bits [c*NIN +: NIN]. Asynchronous to `CELCLK`.
- `o`, output, NCH: filtered NAND per channel.
- `evclr`, input, 1: synchronous clear of all transition counters (macro only).
- `evcnt`, output, NCH*EVCW: channel c at [c*EVCW +: EVCW] (macro only).

## Operation
- Sync: each `i` bit passes through a 2-flop synchroniser. Flops reset to 0.
- Raw: `raw[c]` is the NAND of channel c's synchronised bits, taken combinationally.
- Filter, FILT_CYC ≥ 1: per-channel counter `cnt`, width clog2(FILT_CYC+1), reset value 0.
  - If `raw == o`, `cnt` goes to 0.
  - Else if `cnt == FILT_CYC-1`, then `o <= raw` and `cnt <= 0`.
  - Else `cnt` increments.
  - Any glitch back to `o` restarts the count. The counter never wraps.
- FILT_CYC = 0: `o <= raw` on every edge, a plain register.
- Reset values: `o` = all 1s, which matches NAND of reset-zero sync flops. `cnt` = 0. `evcnt` = 0.
- While `CELRSTN` is low, all state holds at reset values. The deassertion edge is captured by downstream synchronisation in the system, not inside this block.
- A reset asserted mid-count aborts the pending change. `o` returns to 1 asynchronously.
- Channels are fully independent. No shared state exists except `evclr`.

## Timing
- Input change settled before edge E0: sync stage 1 at E0, stage 2 at E1, `raw` valid after E1.
- `o` changes after edge E(1+max(FILT_CYC,1)). Total latency is max(FILT_CYC,1)+2 rising edges.
- A pulse on the raw result shorter than FILT_CYC cycles never reaches `o`.
- Inputs must be stable for ≥1 clock period to be sampled at all. Narrower pulses are undefined.
- `evcnt` updates on the same edge that `o` toggles.

## Configuration
- Macro `NANDN_FILT_EVCNT_EN`.
- Defined:
  - `evclr` and `evcnt` ports exist.
  - Each channel has an EVCW-bit counter that increments on every `o` toggle and saturates at all 1s.
  - If `evclr` is high on the same edge as a toggle, the counter loads 1. Otherwise `evclr` loads 0.
- Undefined: the ports and counters are absent. Filter behaviour is identical.

## Structure
- Package `nandn_filt_pkg` holds:
  - default constants `NANDN_NIN_DEF`, `NANDN_FILT_DEF`, `NANDN_EVCW_DEF`;
  - function `nandn_cntw(filt)` returning the counter width.
- Sub-module `nandn_filt_ch` covers one channel: synchroniser, NAND, filter and optional counter. The top generates NCH instances and slices the buses.

## Test plan
- Reset: NCH=2, NIN=3, FILT_CYC=4. Hold `CELRSTN`=0 → `o`=2'b11 and `evcnt`=0. Release with all `i`=1 → ch0 and ch1 `o` go to 0 exactly 6 edges after the inputs settle.
- Glitch reject: FILT_CYC=4, set one input of ch0 low for 3 clocks → `o[0]` stays 0 and `evcnt[0]` is unchanged.
- Restart: raw differs for 3 cycles, matches for 1, then differs for 4 → `o` toggles only at the end of the second run.
- Bypass: FILT_CYC=0, toggle inputs every 2 clocks → `o` follows with 3-edge latency.
- Reset mid-count: assert `CELRSTN` at `cnt`=2 → `o`=1 immediately. After release, the count starts from 0.
- Counter (macro on, EVCW=2): 5 toggles → `evcnt`=3, saturated. Then `evclr` coincident with a toggle → `evcnt`=1.

Source files
------------

// File: rtl/nandn_filt_pkg.sv
// Shared constants and helpers for the nandn_filt_xloop brick.
//   NANDN_NIN_DEF  : default inputs per channel NAND
//   NANDN_FILT_DEF : default debounce length in clocks
//   NANDN_EVCW_DEF : default transition-counter width
//   nandn_cntw()   : width of the per-channel debounce counter
package nandn_filt_pkg;

    localparam int unsigned NANDN_NIN_DEF  = 2;
    localparam int unsigned NANDN_FILT_DEF = 4;
    localparam int unsigned NANDN_EVCW_DEF = 8;

    // Counter must hold 0..filt; a zero-length filter still gets a 1-bit
    // counter so the declaration stays legal (it is never instantiated).
    function automatic int unsigned nandn_cntw(input int unsigned filt);
        return (filt == 0) ? 1 : $clog2(filt + 1);
    endfunction

endpackage

// File: rtl/nandn_filt_xloop_if.sv
// Signal bundle between the NAND brick and its user.
//   i     : NCH*NIN raw inputs, channel c at [c*NIN +: NIN]
//   o     : NCH filtered NAND outputs
//   evclr : clear of all transition counters (NANDN_FILT_EVCNT_EN only)
//   evcnt : NCH*EVCW transition counts, channel c at [c*EVCW +: EVCW]
//           (NANDN_FILT_EVCNT_EN only)
// master drives inputs, slave is the brick.
interface nandn_filt_xloop_if #(
    parameter int unsigned NCH  = 1,
    parameter int unsigned NIN  = 2,
    parameter int unsigned EVCW = 8
);
    logic [NCH*NIN-1:0] i;
    logic [NCH-1:0]     o;
`ifdef NANDN_FILT_EVCNT_EN
    logic                evclr;
    logic [NCH*EVCW-1:0] evcnt;

    modport master (output i, output evclr, input o, input evcnt);
    modport slave  (input i, input evclr, output o, output evcnt);
`else
    localparam int unsigned unused_evcw = EVCW;

    modport master (output i, input o);
    modport slave  (input i, output o);
`endif
endinterface

// File: rtl/nandn_filt_ch.sv
// One channel of the NAND brick: 2-flop input synchroniser, NAND of the
// synchronised bits, debounce filter and (NANDN_FILT_EVCNT_EN) a saturating
// transition counter.
//   clk, rst_n : clock, asynchronous active-low reset
//   in_bits    : NIN asynchronous inputs
//   o_bit      : filtered NAND, resets to 1
//   evclr      : synchronous counter clear (macro only)
//   evcnt      : EVCW-bit toggle count (macro only)
module nandn_filt_ch
    import nandn_filt_pkg::*;
#(
    parameter int unsigned NIN      = NANDN_NIN_DEF,
    parameter int unsigned FILT_CYC = NANDN_FILT_DEF,
    parameter int unsigned EVCW     = NANDN_EVCW_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [NIN-1:0] in_bits,
    output logic           o_bit
`ifdef NANDN_FILT_EVCNT_EN
    ,
    input  logic           evclr,
    output logic [EVCW-1:0] evcnt
`endif
);

    logic [NIN-1:0] sync1;
    logic [NIN-1:0] sync2;
    logic           raw;
    logic           o_q;
    logic           o_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= in_bits;
            sync2 <= sync1;
        end
    end

    assign raw = ~&sync2;

    if (FILT_CYC == 0) begin : g_bypass
        assign o_nxt = raw;
    end else begin : g_filt
        localparam int unsigned     CW   = nandn_cntw(FILT_CYC);
        localparam logic [CW-1:0]   LAST = CW'(FILT_CYC - 1);

        logic [CW-1:0] cnt;
        logic [CW-1:0] cnt_nxt;
        logic          o_upd;

        // Any cycle where raw agrees with o clears the count, so only an
        // unbroken run of FILT_CYC disagreeing cycles moves the output.
        always_comb begin
            cnt_nxt = '0;
            o_upd   = o_q;
            if (raw != o_q) begin
                if (cnt == LAST) begin
                    o_upd = raw;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt <= '0;
            end else begin
                cnt <= cnt_nxt;
            end
        end

        assign o_nxt = o_upd;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_q <= 1'b1;
        end else begin
            o_q <= o_nxt;
        end
    end

    assign o_bit = o_q;

`ifdef NANDN_FILT_EVCNT_EN
    logic            toggle;
    logic [EVCW-1:0] ev_q;

    assign toggle = o_nxt ^ o_q;

    // A toggle coinciding with a clear counts as the first event after it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ev_q <= '0;
        end else if (toggle) begin
            if (evclr) begin
                ev_q <= EVCW'(1);
            end else if (!(&ev_q)) begin
                ev_q <= ev_q + 1'b1;
            end
        end else if (evclr) begin
            ev_q <= '0;
        end
    end

    assign evcnt = ev_q;
`endif

endmodule

// File: rtl/nandn_filt_xloop.sv
// Multi-channel N-input NAND brick with input synchronisation and per-channel
// debounce. Optional transition counters under macro NANDN_FILT_EVCNT_EN.
//   CELCLK  : clock, rising edge
//   CELRSTN : asynchronous active-low reset
//   CELV, CELG, SUB : supply/ground/substrate ties, no logic function
//   pins    : nandn_filt_xloop_if slave (i, o, and evclr/evcnt with macro)
module nandn_filt_xloop
    import nandn_filt_pkg::*;
#(
    parameter int unsigned NCH      = 1,
    parameter int unsigned NIN      = NANDN_NIN_DEF,
    parameter int unsigned FILT_CYC = NANDN_FILT_DEF,
    parameter int unsigned EVCW     = NANDN_EVCW_DEF
) (
    input  logic              CELCLK,
    input  logic              CELRSTN,
    input  logic              CELV,
    input  logic              CELG,
    input  logic              SUB,
    nandn_filt_xloop_if.slave pins
);

    logic unused_ties;
    assign unused_ties = CELV ^ CELG ^ SUB;

    logic o_ch [NCH];
`ifdef NANDN_FILT_EVCNT_EN
    logic [EVCW-1:0] ev_ch [NCH];
`endif

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        nandn_filt_ch #(
            .NIN      (NIN),
            .FILT_CYC (FILT_CYC),
            .EVCW     (EVCW)
        ) u_ch (
            .clk     (CELCLK),
            .rst_n   (CELRSTN),
            .in_bits (pins.i[c*NIN +: NIN]),
            .o_bit   (o_ch[c])
`ifdef NANDN_FILT_EVCNT_EN
            ,
            .evclr   (pins.evclr),
            .evcnt   (ev_ch[c])
`endif
        );
    end

    // Per-channel results are packed in one process so each bus has a
    // single driver.
    always_comb begin
        pins.o = '1;
        for (int unsigned c = 0; c < NCH; c++) begin
            pins.o[c] = o_ch[c];
        end
    end

`ifdef NANDN_FILT_EVCNT_EN
    always_comb begin
        pins.evcnt = '0;
        for (int unsigned c = 0; c < NCH; c++) begin
            pins.evcnt[c*EVCW +: EVCW] = ev_ch[c];
        end
    end
`endif

endmodule

// File: tb/tb_nandn_filt_xloop.sv
// Bench for nandn_filt_xloop: two instances share the same inputs, one with
// a 4-cycle filter and one with the filter disabled. A sliding-window model
// of the debounce rule provides the expected outputs.
module tb_nandn_filt_xloop;

    localparam int unsigned NCH   = 2;
    localparam int unsigned NIN   = 3;
    localparam int unsigned W     = NCH * NIN;
    localparam int unsigned EVCW  = 2;
    localparam int unsigned FA    = 4;
    localparam int unsigned FB    = 0;
    localparam int unsigned HD    = 8;
    localparam int unsigned MAXEV = (1 << EVCW) - 1;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] stim  = '0;
    logic         evclr = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    nandn_filt_xloop_if #(.NCH(NCH), .NIN(NIN), .EVCW(EVCW)) bus_a ();
    nandn_filt_xloop_if #(.NCH(NCH), .NIN(NIN), .EVCW(EVCW)) bus_b ();

    assign bus_a.i = stim;
    assign bus_b.i = stim;
`ifdef NANDN_FILT_EVCNT_EN
    assign bus_a.evclr = evclr;
    assign bus_b.evclr = evclr;
`endif

    nandn_filt_xloop #(.NCH(NCH), .NIN(NIN), .FILT_CYC(FA), .EVCW(EVCW)) dut_a (
        .CELCLK  (clk),
        .CELRSTN (rst_n),
        .CELV    (1'b1),
        .CELG    (1'b0),
        .SUB     (1'b0),
        .pins    (bus_a.slave)
    );

    nandn_filt_xloop #(.NCH(NCH), .NIN(NIN), .FILT_CYC(FB), .EVCW(EVCW)) dut_b (
        .CELCLK  (clk),
        .CELRSTN (rst_n),
        .CELV    (1'b1),
        .CELG    (1'b0),
        .SUB     (1'b0),
        .pins    (bus_b.slave)
    );

    // ---------------- reference model ----------------
    // Input seen by the NAND at edge k is the input sampled at edge k-2.
    // The output flips at edge k when the NAND result disagreed with it at
    // each of the last max(F,1) edges.
    bit [W-1:0]   in_hist[$];
    bit [NCH-1:0] raw_hist[$];
    bit [NCH-1:0] mo_a;
    bit [NCH-1:0] mo_b;
    int unsigned  mev[NCH];

    function automatic bit [NCH-1:0] nand_of(input bit [W-1:0] v);
        bit [NCH-1:0] r;
        for (int c = 0; c < NCH; c++) r[c] = ~&v[c*NIN +: NIN];
        return r;
    endfunction

    function automatic bit [NCH-1:0] follow(input bit [NCH-1:0] cur, input int unsigned f);
        bit [NCH-1:0] res;
        int unsigned  win;
        bit           all_diff;
        res = cur;
        win = (f == 0) ? 1 : f;
        for (int c = 0; c < NCH; c++) begin
            all_diff = 1'b1;
            for (int j = 0; j < int'(win); j++)
                if (raw_hist[HD-1-j][c] == cur[c]) all_diff = 1'b0;
            if (all_diff) res[c] = ~cur[c];
        end
        return res;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        bit [NCH-1:0] raw_now;
        bit [NCH-1:0] prev_a;
        if (!rst_n) begin
            in_hist.delete();
            in_hist.push_back('0);
            in_hist.push_back('0);
            raw_hist.delete();
            for (int k = 0; k < HD; k++) raw_hist.push_back('1);
            mo_a = '1;
            mo_b = '1;
            for (int c = 0; c < NCH; c++) mev[c] = 0;
        end else begin
            raw_now = nand_of(in_hist[0]);
            raw_hist.push_back(raw_now);
            void'(raw_hist.pop_front());
            in_hist.push_back(stim);
            void'(in_hist.pop_front());
            prev_a = mo_a;
            mo_a = follow(mo_a, FA);
            mo_b = follow(mo_b, FB);
            for (int c = 0; c < NCH; c++) begin
                if (mo_a[c] != prev_a[c])
                    mev[c] = evclr ? 1 : ((mev[c] == MAXEV) ? MAXEV : mev[c] + 1);
                else if (evclr)
                    mev[c] = 0;
            end
        end
    end

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        stim  = '0;
        evclr = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if (bus_a.o !== 2'b11) begin
            n_fail++; $display("FAIL reset_o_a: got %b want 11", bus_a.o);
        end
        n_tests++;
        if (bus_b.o !== 2'b11) begin
            n_fail++; $display("FAIL reset_o_b: got %b want 11", bus_b.o);
        end
`ifdef NANDN_FILT_EVCNT_EN
        n_tests++;
        if (bus_a.evcnt !== 4'h0) begin
            n_fail++; $display("FAIL reset_evcnt: got %h want 0", bus_a.evcnt);
        end
`endif
        stim  = '1;
        rst_n = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            n_tests++;
            if (bus_a.o !== ((k >= 6) ? 2'b00 : 2'b11)) begin
                n_fail++; $display("FAIL release_lat_a edge %0d: got %b want %b", k, bus_a.o, (k >= 6) ? 2'b00 : 2'b11);
            end
            n_tests++;
            if (bus_b.o !== ((k >= 3) ? 2'b00 : 2'b11)) begin
                n_fail++; $display("FAIL release_lat_b edge %0d: got %b want %b", k, bus_b.o, (k >= 3) ? 2'b00 : 2'b11);
            end
        end
    endtask

    task automatic test_glitch();
        for (int k = 0; k < 12; k++) begin
            stim[0] = (k < 3) ? 1'b0 : 1'b1;
            @(negedge clk);
            n_tests++;
            if (bus_a.o[0] !== 1'b0) begin
                n_fail++; $display("FAIL glitch_o0 cyc %0d: got %b want 0", k, bus_a.o[0]);
            end
            n_tests++;
            if (bus_b.o !== mo_b) begin
                n_fail++; $display("FAIL glitch_o_b cyc %0d: got %b want %b", k, bus_b.o, mo_b);
            end
`ifdef NANDN_FILT_EVCNT_EN
            n_tests++;
            if (bus_a.evcnt[EVCW-1:0] !== 2'd1) begin
                n_fail++; $display("FAIL glitch_evcnt0 cyc %0d: got %0d want 1", k, bus_a.evcnt[EVCW-1:0]);
            end
`endif
        end
    endtask

    task automatic test_restart();
        // differ 3, agree 1, then differ until the output moves
        for (int k = 0; k < 4; k++) begin
            stim[0] = (k < 3) ? 1'b0 : 1'b1;
            @(negedge clk);
            n_tests++;
            if (bus_a.o[0] !== 1'b0) begin
                n_fail++; $display("FAIL restart_first_run cyc %0d: got %b want 0", k, bus_a.o[0]);
            end
        end
        stim[0] = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            n_tests++;
            if (bus_a.o[0] !== ((k >= 6) ? 1'b1 : 1'b0)) begin
                n_fail++; $display("FAIL restart_second_run edge %0d: got %b want %b", k, bus_a.o[0], (k >= 6) ? 1'b1 : 1'b0);
            end
        end
        stim[0] = 1'b1;
        repeat (8) @(negedge clk);
        n_tests++;
        if (bus_a.o !== mo_a) begin
            n_fail++; $display("FAIL restart_settle: got %b want %b", bus_a.o, mo_a);
        end
    endtask

    task automatic test_bypass();
        bit lvl[$];
        for (int k = 0; k < 16; k++) begin
            stim[3] = ((k / 2) % 2 == 0) ? 1'b0 : 1'b1;
            lvl.push_back(stim[3]);
            @(negedge clk);
            if (k >= 2) begin
                n_tests++;
                if (bus_b.o[1] !== ~lvl[k-2]) begin
                    n_fail++; $display("FAIL bypass_lat edge %0d: got %b want %b", k, bus_b.o[1], ~lvl[k-2]);
                end
            end
            n_tests++;
            if (bus_a.o[1] !== 1'b0) begin
                n_fail++; $display("FAIL bypass_filtered_ch1 cyc %0d: got %b want 0", k, bus_a.o[1]);
            end
        end
        stim = '1;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        stim[0] = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (bus_a.o !== 2'b11) begin
            n_fail++; $display("FAIL midreset_o_a: got %b want 11", bus_a.o);
        end
        n_tests++;
        if (bus_b.o !== 2'b11) begin
            n_fail++; $display("FAIL midreset_o_b: got %b want 11", bus_b.o);
        end
        stim = '1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            n_tests++;
            if (bus_a.o !== ((k >= 6) ? 2'b00 : 2'b11)) begin
                n_fail++; $display("FAIL midreset_recount edge %0d: got %b want %b", k, bus_a.o, (k >= 6) ? 2'b00 : 2'b11);
            end
        end
    endtask

    task automatic test_random();
        int unsigned hold[NCH];
        for (int c = 0; c < NCH; c++) hold[c] = 0;
        for (int k = 0; k < 400; k++) begin
            for (int c = 0; c < NCH; c++) begin
                if (hold[c] == 0) begin
                    stim[c*NIN +: NIN] = ($urandom_range(0, 1) == 1) ? 3'b111 : 3'($urandom);
                    hold[c] = $urandom_range(1, 7);
                end
                hold[c]--;
            end
`ifdef NANDN_FILT_EVCNT_EN
            evclr = ($urandom_range(0, 15) == 0);
`endif
            @(negedge clk);
            n_tests++;
            if (bus_a.o !== mo_a) begin
                n_fail++; $display("FAIL random_o_a cyc %0d: got %b want %b", k, bus_a.o, mo_a);
            end
            n_tests++;
            if (bus_b.o !== mo_b) begin
                n_fail++; $display("FAIL random_o_b cyc %0d: got %b want %b", k, bus_b.o, mo_b);
            end
`ifdef NANDN_FILT_EVCNT_EN
            for (int c = 0; c < NCH; c++) begin
                n_tests++;
                if (bus_a.evcnt[c*EVCW +: EVCW] !== EVCW'(mev[c])) begin
                    n_fail++; $display("FAIL random_evcnt ch%0d cyc %0d: got %0d want %0d", c, k, bus_a.evcnt[c*EVCW +: EVCW], mev[c]);
                end
            end
`endif
        end
        evclr = 1'b0;
        stim  = '1;
        repeat (8) @(negedge clk);
    endtask

`ifdef NANDN_FILT_EVCNT_EN
    task automatic test_counter();
        evclr = 1'b1;
        @(negedge clk);
        evclr = 1'b0;
        n_tests++;
        if (bus_a.evcnt !== 4'h0) begin
            n_fail++; $display("FAIL counter_clear: got %h want 0", bus_a.evcnt);
        end
        for (int t = 0; t < 5; t++) begin
            stim[3] = ~stim[3];
            repeat (8) @(negedge clk);
        end
        n_tests++;
        if (bus_a.evcnt[EVCW +: EVCW] !== 2'd3) begin
            n_fail++; $display("FAIL counter_saturate: got %0d want 3", bus_a.evcnt[EVCW +: EVCW]);
        end
        n_tests++;
        if (bus_a.evcnt[EVCW-1:0] !== 2'd0) begin
            n_fail++; $display("FAIL counter_ch0_idle: got %0d want 0", bus_a.evcnt[EVCW-1:0]);
        end
        stim[3] = ~stim[3];
        repeat (5) @(negedge clk);
        evclr = 1'b1;
        @(negedge clk);
        evclr = 1'b0;
        n_tests++;
        if (bus_a.evcnt[EVCW +: EVCW] !== 2'd1) begin
            n_fail++; $display("FAIL counter_clear_on_toggle: got %0d want 1", bus_a.evcnt[EVCW +: EVCW]);
        end
        n_tests++;
        if (bus_a.evcnt[EVCW-1:0] !== 2'd0) begin
            n_fail++; $display("FAIL counter_clear_no_toggle: got %0d want 0", bus_a.evcnt[EVCW-1:0]);
        end
        n_tests++;
        if (bus_a.o !== mo_a) begin
            n_fail++; $display("FAIL counter_o_a: got %b want %b", bus_a.o, mo_a);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_glitch();
        test_restart();
        test_bypass();
        test_reset_mid();
        test_random();
`ifdef NANDN_FILT_EVCNT_EN
        test_counter();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
